rob: RTL

Reorder buffer for the out-of-order RV32IM core. It allocates one entry per dispatched instruction in program order and captures results from the common data bus (CDB) and outcomes from the branch unit. It retires completed entries in order, one per cycle, to the architectural register file. On a mispredicted branch it issues a pipeline flush with the corrected next PC. It sits between dispatch/rename (upstream) and the register file plus front-end redirect (downstream).

---
 rtl/rob.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rob.sv
// Reorder buffer for the out-of-order RV32IM core.
// Entries are allocated in program order at the tail and filled by the CDB and
// the branch unit. They retire in order from the head, one per cycle. A
// mispredicted branch flushes every entry when it retires.

package rob_pkg;

    // Result broadcast on the common data bus
    typedef struct packed {
        logic        valid;
        logic [4:0]  rob_id;
        logic [31:0] rd_v;
    } cdb_entry_t;

    // Branch resolution; pc_jalr is the resolved next PC for every branch type
    typedef struct packed {
        logic        valid;
        logic [4:0]  rob_id;
        logic        br_en;
        logic        jalr;
        logic [31:0] pc_jalr;
    } br_entry_t;

    // One in-flight instruction
    typedef struct packed {
        logic        valid;
        logic        rd_valid;
        logic        regf_we;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic [31:0] pc;
        logic        br;
        logic        pred_taken;
        logic        br_actual;
        logic        jalr;
    } rob_entry_t;

endpackage

module rob
    import rob_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_valid,
    output logic        alloc_ready,
    output logic [4:0]  alloc_id,
    input  logic        alloc_regf_we,
    input  logic [4:0]  alloc_rd_s,
    input  logic [31:0] alloc_pc,
    input  logic        alloc_br,
    input  logic [1:0]  alloc_br_predicted,
    input  cdb_entry_t  cdb,
    input  br_entry_t   br,
    input  logic [4:0]  q1_id,
    input  logic [4:0]  q2_id,
    output logic        q1_ready,
    output logic        q2_ready,
    output logic [31:0] q1_v,
    output logic [31:0] q2_v,
    output logic        commit_valid,
    output logic        commit_regf_we,
    output logic [4:0]  commit_rd_s,
    output logic [31:0] commit_rd_v,
    output logic [31:0] commit_pc,
    output logic [4:0]  commit_id,
    output logic        flush,
    output logic [31:0] flush_pc
);

    localparam logic [5:0] FULL = 6'(DEPTH);

    rob_entry_t  entries_q [DEPTH];
    rob_entry_t  entries_d [DEPTH];
    logic [DEPTH-1:0] br_done_q, br_done_d;
    logic [31:0] next_pc_q [DEPTH];
    logic [31:0] next_pc_d [DEPTH];
    logic [4:0]  head_q, head_d;
    logic [4:0]  tail_q, tail_d;
    logic [5:0]  count_q, count_d;

    rob_entry_t  head_entry;
    logic        mispredict;
    logic        do_alloc;
    logic        cdb_hit_q1;
    logic        cdb_hit_q2;

    // Only the taken/not-taken bit of the predictor counter decides a mispredict
    logic        pred_weak_unused;
    assign pred_weak_unused = alloc_br_predicted[0];

    // Retirement and redirect decisions, all from registered state
    always_comb begin
        head_entry     = entries_q[head_q];
        commit_valid   = head_entry.valid && head_entry.rd_valid
                         && (!head_entry.br || br_done_q[head_q]);
        mispredict     = head_entry.br
                         && (head_entry.jalr || (head_entry.br_actual != head_entry.pred_taken));
        flush          = commit_valid && mispredict;
        flush_pc       = next_pc_q[head_q];
        commit_regf_we = commit_valid && head_entry.regf_we;
        commit_rd_s    = head_entry.rd_s;
        commit_rd_v    = head_entry.rd_v;
        commit_pc      = head_entry.pc;
        commit_id      = head_q;
        alloc_ready    = (count_q != FULL) && !flush;
        alloc_id       = tail_q;
        do_alloc       = alloc_valid && alloc_ready;
    end

    // Operand lookups, forwarding a same-cycle CDB broadcast ahead of stored data
    always_comb begin
        cdb_hit_q1 = cdb.valid && (cdb.rob_id == q1_id);
        cdb_hit_q2 = cdb.valid && (cdb.rob_id == q2_id);
        q1_ready   = cdb_hit_q1 || (entries_q[q1_id].valid && entries_q[q1_id].rd_valid);
        q2_ready   = cdb_hit_q2 || (entries_q[q2_id].valid && entries_q[q2_id].rd_valid);
        q1_v       = cdb_hit_q1 ? cdb.rd_v : entries_q[q1_id].rd_v;
        q2_v       = cdb_hit_q2 ? cdb.rd_v : entries_q[q2_id].rd_v;
    end

    // Next-state: result capture, allocation, retirement, then flush on top of all
    always_comb begin
        entries_d = entries_q;
        br_done_d = br_done_q;
        next_pc_d = next_pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + 6'(do_alloc) - 6'(commit_valid);

        if (cdb.valid && entries_q[cdb.rob_id].valid) begin
            entries_d[cdb.rob_id].rd_valid = 1'b1;
            entries_d[cdb.rob_id].rd_v     = cdb.rd_v;
        end

        if (br.valid && entries_q[br.rob_id].valid) begin
            br_done_d[br.rob_id]           = 1'b1;
            entries_d[br.rob_id].br_actual = br.br_en;
            entries_d[br.rob_id].jalr      = br.jalr;
            next_pc_d[br.rob_id]           = br.pc_jalr;
        end

        if (do_alloc) begin
            entries_d[tail_q].valid      = 1'b1;
            entries_d[tail_q].rd_valid   = 1'b0;
            entries_d[tail_q].regf_we    = alloc_regf_we;
            entries_d[tail_q].rd_s       = alloc_rd_s;
            entries_d[tail_q].rd_v       = 32'd0;
            entries_d[tail_q].pc         = alloc_pc;
            entries_d[tail_q].br         = alloc_br;
            entries_d[tail_q].pred_taken = alloc_br_predicted[1];
            entries_d[tail_q].br_actual  = 1'b0;
            entries_d[tail_q].jalr       = 1'b0;
            br_done_d[tail_q]            = 1'b0;
            tail_d                       = tail_q + 5'd1;
        end

        if (commit_valid) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 5'd1;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d  = 5'd0;
            tail_d  = 5'd0;
            count_d = 6'd0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
                next_pc_q[i] <= 32'd0;
            end
            br_done_q <= '0;
            head_q    <= 5'd0;
            tail_q    <= 5'd0;
            count_q   <= 6'd0;
        end else begin
            entries_q <= entries_d;
            next_pc_q <= next_pc_d;
            br_done_q <= br_done_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule
